// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: state sequencing, ImmSrc and ALUControl decode.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in an absorbing ILLEGAL state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t r_state;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:    if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECUTER;
            OP_ITYPE:          r_state <= S_EXECUTEI;
            OP_JAL:            r_state <= S_JAL;
            OP_BEQ:            r_state <= S_BEQ;
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
              r_state   <= S_ILLEGAL;
              r_illegal <= 1'b1;
`else
              // PC was already advanced in FETCH, so this is a no-op.
              r_state <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
        S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
        S_MEMWB:    r_state <= S_FETCH;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_ILLEGAL:  r_state <= S_ILLEGAL;
`endif
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;
  logic [2:0] w_alu_control;

  // Moore outputs; only IRWrite/PCUpdate in FETCH look at MemReady.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = MemReady;
        w_pc_update  = MemReady;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: w_imm_src = 2'b01;
      OP_BEQ:   w_imm_src = 2'b10;
      OP_JAL:   w_imm_src = 2'b11;
      default:  w_imm_src = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) can request a subtract through funct7b5.
  always_comb begin
    case (w_alu_op)
      2'b00:   w_alu_control = 3'b000;
      2'b01:   w_alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  w_alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  // Reset forces every enable and select low immediately, not just after the edge.
  assign PCWrite    = reset_n & (w_pc_update | (w_branch & Zero));
  assign AdrSrc     = reset_n & w_adr_src;
  assign MemWrite   = reset_n & w_mem_write;
  assign IRWrite    = reset_n & w_ir_write;
  assign RegWrite   = reset_n & w_reg_write;
  assign ResultSrc  = reset_n ? w_result_src  : 2'b00;
  assign ALUSrcA    = reset_n ? w_alu_src_a   : 2'b00;
  assign ALUSrcB    = reset_n ? w_alu_src_b   : 2'b00;
  assign ImmSrc     = reset_n ? w_imm_src     : 2'b00;
  assign ALUControl = reset_n ? w_alu_control : 3'b000;
  assign State      = r_state;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign Illegal = r_illegal;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller; honours MC_CTRL_ILLEGAL_TRAP_EN like the design.
module tb_multicycle_controller;
  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] enables();
    return {4'b0, PCWrite, MemWrite, IRWrite, RegWrite};
  endfunction

  typedef struct {
    logic [2:0] f3;
    logic       f7;
    logic [2:0] exp_alu;
  } rvec_t;

  rvec_t rvecs[6] = '{
    '{3'b000, 1'b1, 3'b001},
    '{3'b111, 1'b0, 3'b010},
    '{3'b010, 1'b0, 3'b101},
    '{3'b110, 1'b0, 3'b011},
    '{3'b000, 1'b0, 3'b000},
    '{3'b001, 1'b0, 3'b000}
  };

  initial begin
    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    tick();
    check_val("rst_state", State, 8'd0);
    check_val("rst_en", enables(), 8'h0);
    check_val("rst_srcb", ALUSrcB, 8'd0);
    check_val("rst_illegal", Illegal, 8'd0);
    reset_n = 1'b1;

    // lw
    op = 7'b0000011; funct3 = 3'b010; #1;
    check_val("lw_fetch_state", State, 8'd0);
    check_val("lw_fetch_en", enables(), 8'b1010);
    check_val("lw_fetch_srcb", ALUSrcB, 8'd2);
    check_val("lw_fetch_res", ResultSrc, 8'd2);
    check_val("lw_imm", ImmSrc, 8'd0);
    tick();
    check_val("lw_dec_state", State, 8'd1);
    check_val("lw_dec_srca", ALUSrcA, 8'd1);
    check_val("lw_dec_en", enables(), 8'h0);
    tick();
    check_val("lw_adr_state", State, 8'd2);
    check_val("lw_adr_srca", ALUSrcA, 8'd2);
    check_val("lw_adr_alu", ALUControl, 8'd0);
    tick();
    check_val("lw_rd_state", State, 8'd3);
    check_val("lw_rd_adr", AdrSrc, 8'd1);
    check_val("lw_rd_en", enables(), 8'h0);
    tick();
    check_val("lw_wb_state", State, 8'd4);
    check_val("lw_wb_en", enables(), 8'b0001);
    check_val("lw_wb_res", ResultSrc, 8'd1);
    tick();
    check_val("lw_end_state", State, 8'd0);
    $display("instr lw op=%b", op);

    // sw with two wait cycles in MEMWRITE
    op = 7'b0100011; #1;
    check_val("sw_imm", ImmSrc, 8'd1);
    tick();
    tick();
    check_val("sw_adr_state", State, 8'd2);
    MemReady = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) MemReady = 1'b1;
      #1;
      check_val($sformatf("sw_wr_state%0d", i), State, 8'd5);
      check_val($sformatf("sw_wr_mw%0d", i), MemWrite, 8'd1);
      tick();
    end
    check_val("sw_end_state", State, 8'd0);
    $display("instr sw op=%b", op);

    // R-type ALUControl decode
    op = 7'b0110011;
    foreach (rvecs[k]) begin
      funct3 = rvecs[k].f3; funct7b5 = rvecs[k].f7;
      tick();
      tick();
      check_val($sformatf("r%0d_state", k), State, 8'd6);
      check_val($sformatf("r%0d_alu", k), ALUControl, {5'b0, rvecs[k].exp_alu});
      check_val($sformatf("r%0d_srcb", k), ALUSrcB, 8'd0);
      tick();
      check_val($sformatf("r%0d_wb_en", k), enables(), 8'b0001);
      tick();
      check_val($sformatf("r%0d_end", k), State, 8'd0);
      $display("instr rtype funct3=%b funct7b5=%b", funct3, funct7b5);
    end

    // addi with funct7b5 set must not subtract
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    check_val("i_state", State, 8'd8);
    check_val("i_alu", ALUControl, 8'd0);
    check_val("i_srcb", ALUSrcB, 8'd1);
    tick();
    check_val("i_wb_state", State, 8'd7);
    tick();
    check_val("i_end", State, 8'd0);
    $display("instr itype funct3=%b", funct3);

    // beq taken then not taken
    op = 7'b1100011; funct7b5 = 1'b0; Zero = 1'b1;
    tick();
    check_val("beq_dec_pcw", PCWrite, 8'd0);
    tick();
    check_val("beq_t_state", State, 8'd10);
    check_val("beq_t_pcw", PCWrite, 8'd1);
    check_val("beq_alu", ALUControl, 8'd1);
    check_val("beq_imm", ImmSrc, 8'd2);
    tick();
    check_val("beq_t_end", State, 8'd0);
    Zero = 1'b0;
    tick();
    tick();
    check_val("beq_n_state", State, 8'd10);
    check_val("beq_n_pcw", PCWrite, 8'd0);
    tick();
    check_val("beq_n_end", State, 8'd0);
    $display("instr beq");

    // jal
    op = 7'b1101111;
    tick();
    tick();
    check_val("jal_state", State, 8'd9);
    check_val("jal_pcw", PCWrite, 8'd1);
    check_val("jal_imm", ImmSrc, 8'd3);
    check_val("jal_srcb", ALUSrcB, 8'd2);
    tick();
    check_val("jal_end", State, 8'd0);
    $display("instr jal");

    // reset during a FETCH stall
    MemReady = 1'b0; #1;
    check_val("stall_irw", IRWrite, 8'd0);
    tick();
    check_val("stall_state", State, 8'd0);
    reset_n = 1'b0; #1;
    check_val("stall_rst_en", enables(), 8'h0);
    check_val("stall_rst_srcb", ALUSrcB, 8'd0);
    tick();
    check_val("stall_rst_state", State, 8'd0);
    reset_n = 1'b1; MemReady = 1'b1;
    $display("instr reset in fetch stall");

    // reset during a MEMWRITE wait
    op = 7'b0100011;
    tick();
    tick();
    MemReady = 1'b0;
    tick();
    check_val("mwr_state", State, 8'd5);
    reset_n = 1'b0; #1;
    check_val("mwr_rst_mw", MemWrite, 8'd0);
    check_val("mwr_rst_adr", AdrSrc, 8'd0);
    tick();
    check_val("mwr_rst_state", State, 8'd0);
    reset_n = 1'b1; MemReady = 1'b1;
    $display("instr reset in memwrite wait");

    // unrecognised opcode
    op = 7'b1111111;
    tick();
    check_val("ill_dec_state", State, 8'd1);
    check_val("ill_imm", ImmSrc, 8'd0);
    tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("ill_state%0d", i), State, 8'd11);
      check_val($sformatf("ill_flag%0d", i), Illegal, 8'd1);
      check_val($sformatf("ill_en%0d", i), enables(), 8'h0);
      tick();
    end
    reset_n = 1'b0;
    tick();
    check_val("ill_rst_state", State, 8'd0);
    check_val("ill_rst_flag", Illegal, 8'd0);
    reset_n = 1'b1;
`else
    check_val("ill_state", State, 8'd0);
    check_val("ill_flag", Illegal, 8'd0);
    op = 7'b0000011;
    tick();
    check_val("ill_next_state", State, 8'd1);
`endif
    $display("instr illegal op=%b", 7'b1111111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
